// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial adder sequencer.
//   state_t    : controller FSM state, 2-bit encoding
//   DEF_WIDTH  : default operand/result width
// -----------------------------------------------------------------------------
package serial_add_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_if
// Request/result bundle between a requesting master and serial_add_ctrl.
//   start, a, b, cin : request and operands (master -> slave)
//   busy, done       : status; done is a one-cycle result-valid pulse
//   sum, cout        : held result
//   ovf              : signed overflow, present only when SERIAL_ADD_OVF_EN
//                      is defined
// -----------------------------------------------------------------------------
interface serial_add_ctrl_if #(
    parameter int WIDTH = serial_add_pkg::DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;

    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl_fa_bit.sv
// -----------------------------------------------------------------------------
// fa_bit
// Combinational 1-bit full-adder cell.
//   a, b, c : addend bits and carry in
//   s       : a ^ b ^ c
//   co      : a&b | c&(a^b)
// -----------------------------------------------------------------------------
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ c;
    assign co = (a & b) | (c & p);
endmodule

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder sequencer: one fa_bit cell is stepped over WIDTH cycles,
// LSB first, to form {cout,sum} = a + b + cin.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high; abandons any running operation
//   bus  : serial_add_ctrl_if slave modport (start/a/b/cin in,
//          busy/done/sum/cout[/ovf] out)
// Optional feature: define SERIAL_ADD_OVF_EN to add the signed-overflow
// output ovf (carry into MSB xor carry out of MSB).
// -----------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_ctrl_if.slave  bus
);
    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic             fa_s;
    logic             fa_co;

    fa_bit u_fa (
        .a  (opa[0]),
        .b  (opb[0]),
        .c  (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Partial result with the current cell sum dropped into its bit slot.
    // Writing by position rather than shifting keeps every bit of sreg live,
    // and the value on the last RUN edge is the complete sum.
    always_comb begin
        sreg_nxt      = sreg;
        sreg_nxt[cnt] = fa_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            opa      <= '0;
            opb      <= '0;
            carry    <= 1'b0;
            sreg     <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            bus.ovf  <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        opa      <= bus.a;
                        opb      <= bus.b;
                        carry    <= bus.cin;
                        cnt      <= '0;
                        state    <= RUN;
                        bus.busy <= 1'b1;
                    end else begin
                        state    <= IDLE;
                    end
                end
                RUN: begin
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    carry <= fa_co;
                    sreg  <= sreg_nxt;
                    if (cnt == LAST) begin
                        // Counter holds at terminal count so it never wraps in RUN.
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.sum  <= sreg_nxt;
                        bus.cout <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
                        // carry still holds the carry into the MSB on this edge.
                        bus.ovf  <= carry ^ fa_co;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
